// File: rtl/base_endian_swap_pipe.sv
// base_endian_swap_pipe
//   Flow-controlled byte-order converter. Each beat carries its own swap
//   granularity g: bytes are reversed inside every 2^g-byte group, and g is
//   clamped to a full-bus reversal when it exceeds log2(bytes). The swap is
//   combinational ahead of a chain of 2-entry elastic stages. Every stage
//   ready and valid comes straight from a flop, so i_r never depends
//   combinationally on o_r.
//   Data bus bit order is ascending: byte 0 occupies bits [0:7].
module base_endian_swap_pipe #(
   parameter int bytes  = 8,
   parameter int stages = 1,
   parameter int sbw    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_v,
   output logic                   i_r,
   input  logic [0:8*bytes-1]     i_d,
   input  logic [$clog2(bytes):0] i_gran,
   input  logic [sbw-1:0]         i_s,
   output logic                   o_v,
   input  logic                   o_r,
   output logic [0:8*bytes-1]     o_d,
   output logic [sbw-1:0]         o_s,
   output logic                   o_clamp
);

   localparam int dw = 8 * bytes;
   localparam int lb = $clog2(bytes);
   localparam int pw = dw + sbw + 1;   // payload = {clamp, sideband, data}

   typedef enum logic [1:0] {
      st_empty = 2'd0,
      st_one   = 2'd1,
      st_two   = 2'd2
   } st_e;

   // Reverse bytes inside each group of 2^min(g,lb) bytes.
   function automatic logic [0:dw-1] swap_bytes(input logic [0:dw-1] d,
                                                 input logic [lb:0]   g);
      logic [0:dw-1] r;
      int            ge;
      int            grp;
      int            off;
      int            src;
      ge  = (int'(g) > lb) ? lb : int'(g);
      grp = 32'sd1 << ge;
      r   = '0;
      for (int k = 32'sd0; k < bytes; k++) begin
         off = k % grp;
         src = k - off + grp - 32'sd1 - off;
         r[32'sd8*k +: 8] = d[32'sd8*src +: 8];
      end
      return r;
   endfunction

   logic [0:dw-1] swap_d_s;
   logic          clamp_s;

   // Chain links: index i is the input of stage i, index stages is the output.
   logic [pw-1:0] p_s [0:stages];
   logic          v_s [0:stages];
   logic          r_s [0:stages];

   // Swap and clamp detection for the incoming beat.
   always_comb begin
      swap_d_s = swap_bytes(i_d, i_gran);
      clamp_s  = (int'(i_gran) > lb);
   end

   assign p_s[0]      = {clamp_s, i_s, swap_d_s};
   assign v_s[0]      = i_v;
   assign r_s[stages] = o_r;
   assign i_r         = r_s[0];

   assign o_v     = v_s[stages];
   assign o_d     = p_s[stages][dw-1:0];
   assign o_s     = p_s[stages][dw +: sbw];
   assign o_clamp = p_s[stages][pw-1];

   for (genvar gi = 0; gi < stages; gi++) begin : g_stage
      st_e           state_r;
      st_e           state_nxt_s;
      logic [pw-1:0] head_r;
      logic [pw-1:0] tail_r;
      logic [pw-1:0] head_nxt_s;
      logic [pw-1:0] tail_nxt_s;
      logic          rdy_r;
      logic          vld_r;
      logic          push_s;
      logic          pop_s;

      assign push_s = v_s[gi] & rdy_r;
      assign pop_s  = vld_r & r_s[gi+1];

      // Next-state and entry updates; the head always holds the oldest beat.
      always_comb begin
         state_nxt_s = state_r;
         head_nxt_s  = head_r;
         tail_nxt_s  = tail_r;
         case (state_r)
            st_empty: begin
               if (push_s) begin
                  state_nxt_s = st_one;
                  head_nxt_s  = p_s[gi];
               end else begin
                  state_nxt_s = st_empty;
               end
            end
            st_one: begin
               if (push_s && pop_s) begin
                  state_nxt_s = st_one;
                  head_nxt_s  = p_s[gi];
               end else if (push_s) begin
                  state_nxt_s = st_two;
                  tail_nxt_s  = p_s[gi];
               end else if (pop_s) begin
                  state_nxt_s = st_empty;
               end else begin
                  state_nxt_s = st_one;
               end
            end
            st_two: begin
               // Ready is low here, so only a pop can happen.
               if (pop_s) begin
                  state_nxt_s = st_one;
                  head_nxt_s  = tail_r;
               end else begin
                  state_nxt_s = st_two;
               end
            end
            default: begin
               state_nxt_s = st_empty;
            end
         endcase
      end

      // State register with registered ready/valid derived from the next state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_r <= st_empty;
            rdy_r   <= 1'b1;
            vld_r   <= 1'b0;
         end else begin
            state_r <= state_nxt_s;
            rdy_r   <= (state_nxt_s != st_two);
            vld_r   <= (state_nxt_s != st_empty);
         end
      end

      // Entry registers; cleared on reset so the outputs read zero while idle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            head_r <= '0;
            tail_r <= '0;
         end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
         end
      end

      assign v_s[gi+1] = vld_r;
      assign p_s[gi+1] = head_r;
      assign r_s[gi]   = rdy_r;
   end

endmodule

// File: tb/tb_base_endian_swap_pipe.sv
// Bench for base_endian_swap_pipe: instance a (8 bytes, 1 stage, 1-bit
// sideband) and instance b (4 bytes, 2 stages, 2-bit sideband). Expected
// beats are queued on input handshakes and compared on output handshakes.
module tb_base_endian_swap_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_na, rst_nb;

   logic        a_iv, a_ir, a_ov, a_or, a_oc;
   logic [0:63] a_id, a_od;
   logic [3:0]  a_ig;
   logic [0:0]  a_is, a_os;

   logic        b_iv, b_ir, b_ov, b_or, b_oc;
   logic [0:31] b_id, b_od;
   logic [2:0]  b_ig;
   logic [1:0]  b_is, b_os;

   base_endian_swap_pipe #(.bytes(8), .stages(1), .sbw(1)) dut_a (
      .clk(clk), .rst_n(rst_na), .i_v(a_iv), .i_r(a_ir), .i_d(a_id),
      .i_gran(a_ig), .i_s(a_is), .o_v(a_ov), .o_r(a_or), .o_d(a_od),
      .o_s(a_os), .o_clamp(a_oc));

   base_endian_swap_pipe #(.bytes(4), .stages(2), .sbw(2)) dut_b (
      .clk(clk), .rst_n(rst_nb), .i_v(b_iv), .i_r(b_ir), .i_d(b_id),
      .i_gran(b_ig), .i_s(b_is), .o_v(b_ov), .o_r(b_or), .o_d(b_od),
      .o_s(b_os), .o_clamp(b_oc));

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  s;
      logic        c;
   } sb_t;

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  g;
      logic [1:0]  s;
      logic [63:0] e;
      logic        c;
   } vec_t;

   sb_t  qa[$];
   sb_t  qb[$];
   sb_t  a_exp, b_exp, ea, eb;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   rand_or = 1'b0;
   logic t_ir;
   bit          a_hold, b_hold;
   logic [63:0] a_hd, b_hd;
   logic        a_hc, b_hc;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Independent reference: byte k counted from the most significant byte.
   function automatic logic [63:0] ref_swap(input logic [63:0] d, input int nb, input int g);
      logic [63:0] r;
      int lb, ge, gs;
      lb = 0;
      while ((1 << lb) < nb) lb++;
      ge = (g > lb) ? lb : g;
      gs = 1 << ge;
      r  = '0;
      for (int grp = 0; grp < nb; grp += gs)
         for (int j = 0; j < gs; j++)
            r[(nb-1-(grp+j))*8 +: 8] = d[(nb-1-(grp+gs-1-j))*8 +: 8];
      return r;
   endfunction

   function automatic sb_t mk(input logic [63:0] d, input logic [1:0] s, input logic c);
      sb_t r;
      r.d = d; r.s = s; r.c = c;
      return r;
   endfunction

   // Monitor a: hold-stability, scoreboard pop on output handshake, push on input handshake.
   always @(negedge clk) begin
      if (!rst_na) begin
         a_hold = 1'b0;
      end else begin
         if (a_hold) begin
            chk("a_hold_v", a_ov, 1);
            chk("a_hold_d", a_od, a_hd);
            chk("a_hold_c", a_oc, a_hc);
         end
         a_hold = a_ov && !a_or;
         a_hd = a_od;
         a_hc = a_oc;
         if (a_ov && a_or) begin
            if (qa.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL a_unexpected_beat: got %h want none", a_od);
            end else begin
               ea = qa.pop_front();
               chk("a_data", a_od, ea.d);
               chk("a_side", a_os, ea.s);
               chk("a_clamp", a_oc, ea.c);
            end
         end
         if (a_iv && a_ir) qa.push_back(a_exp);
      end
   end

   // Monitor b: same checks for the 2-stage instance.
   always @(negedge clk) begin
      if (!rst_nb) begin
         b_hold = 1'b0;
      end else begin
         if (b_hold) begin
            chk("b_hold_v", b_ov, 1);
            chk("b_hold_d", b_od, b_hd);
            chk("b_hold_c", b_oc, b_hc);
         end
         b_hold = b_ov && !b_or;
         b_hd = b_od;
         b_hc = b_oc;
         if (b_ov && b_or) begin
            if (qb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL b_unexpected_beat: got %h want none", b_od);
            end else begin
               eb = qb.pop_front();
               chk("b_data", b_od, eb.d);
               chk("b_side", b_os, eb.s);
               chk("b_clamp", b_oc, eb.c);
            end
         end
         if (b_iv && b_ir) qb.push_back(b_exp);
      end
   end

   // Random sink stall for a; i_r must not move when o_r changes mid-cycle.
   always @(posedge clk) begin
      if (rand_or) begin
         #1;
         t_ir = a_ir;
         a_or = 1'($urandom_range(0, 1));
         #1;
         chk("a_ir_comb", a_ir, t_ir);
      end
   end

   task automatic drive_a(input logic [63:0] d, input logic [3:0] g, input logic s,
                          input sb_t e, output int cyc);
      bit acc;
      a_id = d; a_ig = g; a_is = s; a_exp = e; a_iv = 1'b1;
      cyc = 0; acc = 1'b0;
      while (!acc && cyc < 1000) begin
         @(negedge clk); acc = a_ir;
         @(posedge clk); #1; cyc++;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL a_accept_timeout: got no accept want accept");
      end
      a_iv = 1'b0;
   endtask

   task automatic drive_b(input logic [63:0] d, input logic [2:0] g, input logic [1:0] s,
                          input sb_t e, output int cyc);
      bit acc;
      b_id = d[31:0]; b_ig = g; b_is = s; b_exp = e; b_iv = 1'b1;
      cyc = 0; acc = 1'b0;
      while (!acc && cyc < 1000) begin
         @(negedge clk); acc = b_ir;
         @(posedge clk); #1; cyc++;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL b_accept_timeout: got no accept want accept");
      end
      b_iv = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((qa.size() != 0 || qb.size() != 0) && k < 500) begin
         @(posedge clk); #1; k++;
      end
      chk("drain_qa", qa.size(), 0);
      chk("drain_qb", qb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t ta[8];
      vec_t tb[5];
      int   cyc;
      logic [63:0] rd;
      logic [3:0]  rg;
      logic        rs;

      ta[0] = '{64'h0011223344556677, 4'd3,  2'd0, 64'h7766554433221100, 1'b0};
      ta[1] = '{64'h0011223344556677, 4'd0,  2'd0, 64'h0011223344556677, 1'b0};
      ta[2] = '{64'h0011223344556677, 4'd1,  2'd1, 64'h1100332255447766, 1'b0};
      ta[3] = '{64'h0011223344556677, 4'd2,  2'd0, 64'h3322110077665544, 1'b0};
      ta[4] = '{64'h0011223344556677, 4'd4,  2'd1, 64'h7766554433221100, 1'b1};
      ta[5] = '{64'h0123456789abcdef, 4'd15, 2'd0, 64'hefcdab8967452301, 1'b1};
      ta[6] = '{64'h0123456789abcdef, 4'd1,  2'd1, 64'h23016745ab89efcd, 1'b0};
      ta[7] = '{64'h0123456789abcdef, 4'd2,  2'd0, 64'h67452301efcdab89, 1'b0};

      tb[0] = '{64'hAABBCCDD, 4'd3, 2'd1, 64'hDDCCBBAA, 1'b1};
      tb[1] = '{64'hAABBCCDD, 4'd2, 2'd2, 64'hDDCCBBAA, 1'b0};
      tb[2] = '{64'hAABBCCDD, 4'd1, 2'd3, 64'hBBAADDCC, 1'b0};
      tb[3] = '{64'hAABBCCDD, 4'd0, 2'd0, 64'hAABBCCDD, 1'b0};
      tb[4] = '{64'h12345678, 4'd7, 2'd1, 64'h78563412, 1'b1};

      rst_na = 1'b0; rst_nb = 1'b0;
      a_iv = 1'b0; a_id = '0; a_ig = '0; a_is = '0; a_or = 1'b1; a_exp = '0;
      b_iv = 1'b0; b_id = '0; b_ig = '0; b_is = '0; b_or = 1'b1; b_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("a_rst_ov", a_ov, 0);
      chk("a_rst_od", a_od, 0);
      chk("a_rst_oc", a_oc, 0);
      chk("b_rst_ov", b_ov, 0);
      chk("b_rst_od", b_od, 0);
      chk("b_rst_os", b_os, 0);
      rst_na = 1'b1; rst_nb = 1'b1;
      @(posedge clk); #1;
      chk("a_rst_ir", a_ir, 1);
      chk("b_rst_ir", b_ir, 1);

      // Table on a: back-to-back beats, one-cycle latency, unstalled.
      for (int i = 0; i < 8; i++) begin
         drive_a(ta[i].d, ta[i].g, ta[i].s[0], mk(ta[i].e, {1'b0, ta[i].s[0]}, ta[i].c), cyc);
         chk("a_tbl_cyc", cyc, 1);
         chk("a_tbl_ov", a_ov, 1);
         chk("a_tbl_d", a_od, ta[i].e);
         chk("a_tbl_c", a_oc, ta[i].c);
      end
      drain();

      // Table on b: clamp and granularities on a 4-byte bus, two stages.
      for (int i = 0; i < 5; i++) begin
         drive_b(tb[i].d, tb[i].g[2:0], tb[i].s, mk(tb[i].e, tb[i].s, tb[i].c), cyc);
         chk("b_tbl_cyc", cyc, 1);
      end
      drain();

      // a: sink stalled 5 cycles while 4 beats are offered.
      a_or = 1'b0;
      fork
         begin
            repeat (5) @(posedge clk);
            #1;
            a_or = 1'b1;
         end
      join_none
      for (int i = 0; i < 4; i++) begin
         rd = 64'h0102030405060708 + 64'(i) * 64'h1111;
         drive_a(rd, 4'd2, 1'(i), mk(ref_swap(rd, 8, 2), 2'(i % 2), 1'b0), cyc);
         if (i == 0) chk("a_one_ir", a_ir, 1);
         if (i == 1) chk("a_full_ir", a_ir, 0);
      end
      drain();

      // b: capacity of two stages is four beats.
      b_or = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd = 64'h10203040 + 64'(i);
         drive_b(rd, 3'd1, 2'(i), mk(ref_swap(rd, 4, 1), 2'(i), 1'b0), cyc);
         if (i == 1) chk("b_half_ir", b_ir, 1);
         if (i == 3) chk("b_full_ir", b_ir, 0);
      end
      b_or = 1'b1;
      drain();

      // b: reset with two beats buffered, then latency after release.
      b_or = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd = 64'h55667788 + 64'(i);
         drive_b(rd, 3'd2, 2'd3, mk(ref_swap(rd, 4, 2), 2'd3, 1'b0), cyc);
      end
      chk("b_pre_rst_ov", b_ov, 1);
      #2;
      rst_nb = 1'b0;
      #1;
      chk("b_mid_rst_ov", b_ov, 0);
      chk("b_mid_rst_od", b_od, 0);
      chk("b_mid_rst_oc", b_oc, 0);
      qb.delete();
      @(posedge clk); #1;
      rst_nb = 1'b1;
      b_or = 1'b1;
      @(posedge clk); #1;
      chk("b_post_rst_ir", b_ir, 1);
      rd = 64'hCAFE0123;
      drive_b(rd, 3'd2, 2'd2, mk(ref_swap(rd, 4, 2), 2'd2, 1'b0), cyc);
      chk("b_lat1_ov", b_ov, 0);
      @(posedge clk); #1;
      chk("b_lat2_ov", b_ov, 1);
      chk("b_lat2_d", b_od, ref_swap(rd, 4, 2));
      drain();

      // a: random valid/ready, granularity and sideband against the reference.
      rand_or = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         rd = {$urandom, $urandom};
         rg = 4'($urandom_range(0, 7));
         rs = 1'($urandom_range(0, 1));
         drive_a(rd, rg, rs, mk(ref_swap(rd, 8, int'(rg)), {1'b0, rs}, (rg > 4'd3)), cyc);
      end
      rand_or = 1'b0;
      @(posedge clk); #3;
      a_or = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
